// File: rtl/instr_sequencer.sv
// Program-driven instruction source: plays a small instruction RAM onto INSTR with a timed EXEC strobe.
// Optional single-step mode (adds STEP input and PAUSE state) is enabled by defining SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int         ADDR_W       = 4,
  parameter int         SETUP_CYCLES = 4,
  parameter int         PULSE_CYCLES = 2,
  parameter int         HOLD_CYCLES  = 8,
  parameter logic [3:0] HALT_OPCODE  = 4'hF
) (
  input  logic              CLK100MHZ,
  input  logic              RESET,
  input  logic              PROG_WE,
  input  logic [ADDR_W-1:0] PROG_ADDR,
  input  logic [15:0]       PROG_DATA,
  input  logic              START,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              STEP,
`endif
  output logic [15:0]       INSTR,
  output logic              EXEC,
  output logic [ADDR_W-1:0] PC,
  output logic              BUSY,
  output logic              DONE
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int MAX_CYC = (SETUP_CYCLES > PULSE_CYCLES)
                           ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                           : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PC_LAST    = '1;

  // S_LOAD is the one-cycle fetch of word 0 before the first instruction is presented.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_FIRE,
    S_HOLD,
    S_DONE
`ifdef SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       instr_q;
  logic              exec_q;
  logic [ADDR_W-1:0] pc_q;
  logic              busy_q;
  logic              done_q;

  logic [15:0]       mem_q [0:DEPTH-1];
  logic [15:0]       rd_data_q;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              wr_en_d;
  logic              idle_like_d;
  logic              rd_is_halt_d;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;
  logic step_rise_d;
  assign step_rise_d = STEP && !step_q;
`endif

  always_comb begin
    idle_like_d = (state_q == S_IDLE) || (state_q == S_DONE);
    wr_en_d     = PROG_WE && idle_like_d;
    rd_addr_d   = pc_q;
    if (idle_like_d) begin
      rd_addr_d = '0;
    end else if (state_q == S_HOLD) begin
      rd_addr_d = pc_q + ADDR_W'(1);
    end
    rd_is_halt_d = (rd_data_q[15:12] == HALT_OPCODE);
  end

  // Write-first read port so a write landing with START is seen by the fetch of word 0.
  always_ff @(posedge CLK100MHZ) begin
    if (wr_en_d) begin
      mem_q[PROG_ADDR] <= PROG_DATA;
    end
    if (wr_en_d && (PROG_ADDR == rd_addr_d)) begin
      rd_data_q <= PROG_DATA;
    end else begin
      rd_data_q <= mem_q[rd_addr_d];
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      exec_q  <= 1'b0;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      step_q  <= 1'b0;
`endif
    end else begin
`ifdef SEQ_SINGLE_STEP_EN
      step_q <= STEP;
`endif
      case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            pc_q    <= '0;
            done_q  <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (rd_is_halt_d) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            instr_q <= rd_data_q;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= '0;
            exec_q  <= 1'b1;
            state_q <= S_FIRE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FIRE: begin
          if (cnt_q == PULSE_LAST) begin
            cnt_q   <= '0;
            exec_q  <= 1'b0;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q <= '0;
            // rd_data_q already holds word PC+1, prefetched during HOLD.
            if ((pc_q == PC_LAST) || rd_is_halt_d) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              pc_q    <= pc_q + ADDR_W'(1);
              instr_q <= rd_data_q;
`ifdef SEQ_SINGLE_STEP_EN
              state_q <= S_PAUSE;
`else
              state_q <= S_SETUP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE: begin
          if (step_rise_d) begin
            cnt_q   <= '0;
            state_q <= S_SETUP;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign INSTR = instr_q;
  assign EXEC  = exec_q;
  assign PC    = pc_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table-driven program runs plus hand-written
// sequences for same-edge write/start, reset mid-FIRE and (optionally) single-step.
module tb_instr_sequencer;

  localparam int SETUP_C = 4;
  localparam int PULSE_C = 2;
  localparam int HOLD_C  = 8;
  localparam int PERIOD  = SETUP_C + PULSE_C + HOLD_C;
  localparam int LIMIT   = 16 * PERIOD + 40;

  logic        clk;
  logic        RESET;
  logic        PROG_WE;
  logic [3:0]  PROG_ADDR;
  logic [15:0] PROG_DATA;
  logic        START;
`ifdef SEQ_SINGLE_STEP_EN
  logic        STEP;
`endif
  logic [15:0] INSTR;
  logic        EXEC;
  logic [3:0]  PC;
  logic        BUSY;
  logic        DONE;

  instr_sequencer dut (
    .CLK100MHZ (clk),
    .RESET     (RESET),
    .PROG_WE   (PROG_WE),
    .PROG_ADDR (PROG_ADDR),
    .PROG_DATA (PROG_DATA),
    .START     (START),
`ifdef SEQ_SINGLE_STEP_EN
    .STEP      (STEP),
`endif
    .INSTR     (INSTR),
    .EXEC      (EXEC),
    .PC        (PC),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] tb_mem [16];

  typedef struct {
    int          len;
    logic [15:0] base;
    bit          halt;
    logic [15:0] halt_word;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [3:0] a, input logic [15:0] d);
    PROG_WE   = 1'b1;
    PROG_ADDR = a;
    PROG_DATA = d;
    tb_mem[a] = d;
    @(negedge clk);
    PROG_WE   = 1'b0;
  endtask

  task automatic load_test1();
    logic [15:0] prog [6];
    prog = '{16'h8008, 16'h8104, 16'h0201, 16'hA200, 16'h9300, 16'hF000};
    for (int i = 0; i < 6; i++) load_word(4'(i), prog[i]);
  endtask

  // Scoreboard run: expected words are queued from the bench's program model, then popped on each EXEC rise.
  task automatic run_check(input string tag, input bit do_wr, input logic [3:0] wa, input logic [15:0] wd,
                           output int n_pulses, output int done_idx, output bit saw_busy);
    logic [15:0] exp_q [$];
    logic [15:0] e;
    logic [15:0] held;
    logic [15:0] last_word;
    int          exp_pc;
    int          last_rise;
    int          hi;
    logic        prev;

    if (do_wr) tb_mem[wa] = wd;
    exp_pc = 0;
    for (int i = 0; i < 16; i++) begin
      if (tb_mem[i][15:12] == 4'hF) break;
      exp_q.push_back(tb_mem[i]);
      exp_pc = i;
    end

    START = 1'b1;
    if (do_wr) begin
      PROG_WE = 1'b1; PROG_ADDR = wa; PROG_DATA = wd;
    end
    @(negedge clk);
    START = 1'b0; PROG_WE = 1'b0;

    n_pulses = 0; done_idx = -1; saw_busy = 1'b0;
    prev = 1'b0; hi = 0; held = '0; last_rise = 0; last_word = '0;
    for (int idx = 0; idx < LIMIT; idx++) begin
      if (BUSY) saw_busy = 1'b1;
      if (EXEC && !prev) begin
        if (exp_q.size() == 0) begin
          check({tag, " extra exec"}, 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({tag, " instr"}, INSTR, e);
          check({tag, " pc"}, PC, n_pulses);
          $display("[TB] %s exec %0d pc=%0d instr=%h t=%0d", tag, n_pulses, PC, INSTR, idx);
        end
        if (n_pulses == 0) check({tag, " first exec delay"}, idx, SETUP_C + 1);
        else               check({tag, " exec spacing"}, idx - last_rise, PERIOD);
        last_rise = idx; n_pulses++; hi = 0; held = INSTR; last_word = INSTR;
      end
      if (EXEC) begin
        hi++;
        check({tag, " instr stable"}, INSTR, held);
      end
      if (!EXEC && prev) check({tag, " exec width"}, hi, PULSE_C);
      prev = EXEC;
      if (DONE) begin
        done_idx = idx;
        break;
      end
      @(negedge clk);
    end
    check({tag, " done reached"}, done_idx >= 0, 1);
    check({tag, " pending words"}, exp_q.size(), 0);
    check({tag, " final pc"}, PC, exp_pc);
    check({tag, " final exec"}, EXEC, 0);
    check({tag, " final busy"}, BUSY, 0);
    if (n_pulses > 0) check({tag, " final instr"}, INSTR, last_word);
    $display("[TB] %s run: %0d pulses, done at t=%0d, pc=%0d", tag, n_pulses, done_idx, PC);
  endtask

  task automatic count_rises(input int cycles, output int cnt, output logic [15:0] ins);
    logic prev;
    prev = EXEC; cnt = 0; ins = '0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (EXEC && !prev) begin
        cnt++;
        ins = INSTR;
      end
      prev = EXEC;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [4];
    int          np, di, rises;
    bit          sb, hit;
    logic        prev;
    logic [15:0] ins;

    RESET = 1'b1; PROG_WE = 1'b0; PROG_ADDR = '0; PROG_DATA = '0; START = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    STEP = 1'b0;
`endif
    for (int i = 0; i < 16; i++) tb_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset instr", INSTR, 0);
    check("reset exec", EXEC, 0);
    check("reset pc", PC, 0);
    check("reset busy", BUSY, 0);
    check("reset done", DONE, 0);
    RESET = 1'b0;
    @(negedge clk);

`ifdef SEQ_SINGLE_STEP_EN
    load_test1();
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    count_rises(50, rises, ins);
    check("step first exec count", rises, 1);
    check("step first instr", ins, 16'h8008);
    check("step pause busy", BUSY, 1);
    check("step pause done", DONE, 0);
    for (int s = 1; s <= 3; s++) begin
      STEP = 1'b1;
      @(negedge clk);
      STEP = 1'b0;
      count_rises(40, rises, ins);
      check("step exec count", rises, 1);
      check("step instr", ins, tb_mem[s]);
      check("step pc", PC, s);
      check("step busy", BUSY, 1);
      $display("[TB] step %0d exec instr=%h pc=%0d", s, ins, PC);
    end
`else
    // Reference program: 5 instructions then halt.
    load_test1();
    run_check("prog1", 1'b0, 4'd0, 16'h0, np, di, sb);
    check("prog1 pulses", np, 5);
    check("prog1 pc", PC, 4);
    check("prog1 done", DONE, 1);

    // Write to word 0 on the same edge as START: the run must see the new word.
    run_check("wr+start", 1'b1, 4'd0, 16'h8055, np, di, sb);
    check("wr+start pulses", np, 5);

    vecs[0] = '{16, 16'h8000, 1'b0, 16'h0000};
    vecs[1] = '{0,  16'h0000, 1'b1, 16'hF123};
    vecs[2] = '{3,  16'hA100, 1'b1, 16'hF000};
    vecs[3] = '{15, 16'h2000, 1'b1, 16'hFFFF};
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].len; i++) load_word(4'(i), vecs[v].base + 16'(i));
      if (vecs[v].halt) load_word(4'(vecs[v].len), vecs[v].halt_word);
      run_check($sformatf("vec%0d", v), 1'b0, 4'd0, 16'h0, np, di, sb);
      check($sformatf("vec%0d pulses", v), np, vecs[v].len);
      check($sformatf("vec%0d pc", v), PC, (vecs[v].len > 0) ? vecs[v].len - 1 : 0);
      check($sformatf("vec%0d done", v), DONE, 1);
      if (vecs[v].len == 0) begin
        check("halt0 done delay", di, 1);
        check("halt0 busy seen", sb, 0);
      end
    end

    // Reset during the second FIRE; a write and a START issued mid-run must be ignored.
    load_test1();
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    rises = 0; hit = 1'b0; prev = 1'b0;
    for (int idx = 0; idx < 60; idx++) begin
      if (EXEC && !prev) begin
        rises++;
        if (rises == 2) begin
          check("busy start ignored", idx, SETUP_C + 1 + PERIOD);
          check("second exec pc", PC, 1);
          hit = 1'b1;
          break;
        end
      end
      prev = EXEC;
      if (idx == 3) begin
        PROG_WE = 1'b1; PROG_ADDR = 4'd2; PROG_DATA = 16'h1234; START = 1'b1;
      end
      @(negedge clk);
      PROG_WE = 1'b0; START = 1'b0;
    end
    check("second exec seen", hit, 1);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    check("mid-fire reset exec", EXEC, 0);
    check("mid-fire reset pc", PC, 0);
    check("mid-fire reset instr", INSTR, 0);
    check("mid-fire reset busy", BUSY, 0);
    check("mid-fire reset done", DONE, 0);
    $display("[TB] reset mid-fire: exec=%0d pc=%0d", EXEC, PC);
    run_check("after reset", 1'b0, 4'd0, 16'h0, np, di, sb);
    check("after reset pulses", np, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
